// File: rtl/pool_layer_pkg.sv
// Shared definitions for the pool layer: bus widths, DRAM base addresses,
// default map geometry, FSM state type and a counter-width helper.
package pool_layer_pkg;

    localparam int CNN_DATA_WIDTH = 32;
    localparam int CNN_ADDR_WIDTH = 18;

    // DRAM layout: conv output maps, then pooled output maps
    localparam int CONV_OUT_BASE  = 0;
    localparam int POOL_OUT_BASE  = 4096;

    // conv_layer output geometry consumed by the pool stage
    localparam int POOL_IN_W      = 24;
    localparam int POOL_IN_H      = 24;
    localparam int POOL_CH        = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } pool_state_t;

    // Width of a counter that must hold 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_layer_addr_gen.sv
// Window/tap counters for the 2x2 stride-2 pool stage.
// Loop order: channel, output row, output column, tap 0..3.
// addr_in addresses the tap the counters will hold after this cycle's
// step/clear; addr_out addresses the window the counters hold now.
module pool_addr_gen
    import pool_layer_pkg::*;
#(
    parameter int ADDR_WIDTH = CNN_ADDR_WIDTH,
    parameter int IN_W       = POOL_IN_W,
    parameter int IN_H       = POOL_IN_H,
    parameter int CH         = POOL_CH,
    parameter int SRC_BASE   = CONV_OUT_BASE,
    parameter int DST_BASE   = POOL_OUT_BASE
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  step,
    input  logic                  clear,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  first_tap,
    output logic                  last_tap,
    output logic                  last_window
);

    localparam int OUT_W = IN_W / 2;
    localparam int OUT_H = IN_H / 2;
    localparam int CW    = cnt_width(CH);
    localparam int RW    = cnt_width(OUT_H);
    localparam int XW    = cnt_width(OUT_W);

    localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);
    localparam logic [RW-1:0] R_LAST  = RW'(OUT_H - 1);
    localparam logic [XW-1:0] C_LAST  = XW'(OUT_W - 1);

    localparam logic [ADDR_WIDTH-1:0] SRC_A   = ADDR_WIDTH'(SRC_BASE);
    localparam logic [ADDR_WIDTH-1:0] DST_A   = ADDR_WIDTH'(DST_BASE);
    localparam logic [ADDR_WIDTH-1:0] MAP_IN  = ADDR_WIDTH'(IN_W * IN_H);
    localparam logic [ADDR_WIDTH-1:0] ROW_IN  = ADDR_WIDTH'(IN_W);
    localparam logic [ADDR_WIDTH-1:0] MAP_OUT = ADDR_WIDTH'(OUT_W * OUT_H);
    localparam logic [ADDR_WIDTH-1:0] ROW_OUT = ADDR_WIDTH'(OUT_W);

    logic [1:0]    k_q,  k_d;
    logic [XW-1:0] c_q,  c_d;
    logic [RW-1:0] r_q,  r_d;
    logic [CW-1:0] ch_q, ch_d;

    // Counter registers
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            k_q  <= '0;
            c_q  <= '0;
            r_q  <= '0;
            ch_q <= '0;
        end else begin
            k_q  <= k_d;
            c_q  <= c_d;
            r_q  <= r_d;
            ch_q <= ch_d;
        end
    end

    // Nested tap -> column -> row -> channel advance, wrapping to zero at the end
    always_comb begin
        k_d  = k_q;
        c_d  = c_q;
        r_d  = r_q;
        ch_d = ch_q;
        if (clear) begin
            k_d  = '0;
            c_d  = '0;
            r_d  = '0;
            ch_d = '0;
        end else if (step) begin
            if (k_q != 2'd3) begin
                k_d = k_q + 2'd1;
            end else begin
                k_d = '0;
                if (c_q != C_LAST) begin
                    c_d = c_q + XW'(1);
                end else begin
                    c_d = '0;
                    if (r_q != R_LAST) begin
                        r_d = r_q + RW'(1);
                    end else begin
                        r_d  = '0;
                        ch_d = (ch_q != CH_LAST) ? ch_q + CW'(1) : '0;
                    end
                end
            end
        end
    end

    // Tap (y, x) = (2r + k[1], 2c + k[0]); all arithmetic wraps at ADDR_WIDTH
    always_comb begin
        addr_in  = SRC_A
                 + ADDR_WIDTH'(ch_d) * MAP_IN
                 + ADDR_WIDTH'({r_d, k_d[1]}) * ROW_IN
                 + ADDR_WIDTH'({c_d, k_d[0]});
        addr_out = DST_A
                 + ADDR_WIDTH'(ch_q) * MAP_OUT
                 + ADDR_WIDTH'(r_q) * ROW_OUT
                 + ADDR_WIDTH'(c_q);
    end

    // Position flags for the FSM
    always_comb begin
        first_tap   = (k_q == 2'd0);
        last_tap    = (k_q == 2'd3);
        last_window = (c_q == C_LAST) && (r_q == R_LAST) && (ch_q == CH_LAST);
    end

endmodule

// File: rtl/pool_layer.sv
// 2x2 / stride-2 signed max-pool stage. Reads conv feature maps from DRAM
// one request at a time, folds each window to its signed maximum and writes
// the pooled maps back. All outputs are registered.
module pool_layer
    import pool_layer_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int ADDR_WIDTH = CNN_ADDR_WIDTH,
    parameter int IN_W       = POOL_IN_W,
    parameter int IN_H       = POOL_IN_H,
    parameter int CH         = POOL_CH,
    parameter int SRC_BASE   = CONV_OUT_BASE,
    parameter int DST_BASE   = POOL_OUT_BASE
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  dram_en_wr,
    output logic                  busy,
    output logic                  done
);

    if ((IN_W % 2) != 0) begin : g_bad_in_w
        $error("pool_layer: IN_W must be even");
    end
    if ((IN_H % 2) != 0) begin : g_bad_in_h
        $error("pool_layer: IN_H must be even");
    end

    pool_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] max_q, max_d, fold;
    logic [ADDR_WIDTH-1:0] gen_addr_in, gen_addr_out;
    logic                  first_tap, last_tap, last_window;
    logic                  step, clear;

    logic [ADDR_WIDTH-1:0] addr_in_d, addr_out_d;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic                  rd_d, wr_d, busy_d, done_d;

    // Counters step on every tap fold except the last; the window advance
    // happens in WR so addr_out and last_window still see the current window.
    always_comb begin
        clear = (state_q == ST_IDLE) && enable;
        step  = ((state_q == ST_WAIT) && valid && !last_tap) || (state_q == ST_WR);
    end

    pool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IN_W       (IN_W),
        .IN_H       (IN_H),
        .CH         (CH),
        .SRC_BASE   (SRC_BASE),
        .DST_BASE   (DST_BASE)
    ) u_addr_gen (
        .clk         (clk),
        .srstn       (srstn),
        .step        (step),
        .clear       (clear),
        .addr_in     (gen_addr_in),
        .addr_out    (gen_addr_out),
        .first_tap   (first_tap),
        .last_tap    (last_tap),
        .last_window (last_window)
    );

    // State register
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RD;
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: if (valid) state_d = last_tap ? ST_WR : ST_RD;
            ST_WR:   state_d = last_window ? ST_DONE : ST_RD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Max fold: tap 0 loads unconditionally, later taps replace only when strictly greater
    always_comb begin
        fold = max_q;
        if (first_tap || ($signed(data_in) > $signed(max_q))) begin
            fold = data_in;
        end
        max_d = max_q;
        if ((state_q == ST_WAIT) && valid) begin
            max_d = fold;
        end
    end

    // Output next values, decoded from the state being entered so they register in step with it
    always_comb begin
        rd_d       = (state_d == ST_RD);
        wr_d       = (state_d == ST_WR);
        busy_d     = (state_d == ST_RD) || (state_d == ST_WAIT) || (state_d == ST_WR);
        done_d     = (state_d == ST_DONE);
        addr_in_d  = (state_d == ST_RD) ? gen_addr_in  : addr_in;
        addr_out_d = (state_d == ST_WR) ? gen_addr_out : addr_out;
        data_out_d = (state_d == ST_WR) ? max_d        : data_out;
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            max_q      <= '0;
            addr_in    <= '0;
            addr_out   <= '0;
            data_out   <= '0;
            dram_en_rd <= 1'b0;
            dram_en_wr <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            max_q      <= max_d;
            addr_in    <= addr_in_d;
            addr_out   <= addr_out_d;
            data_out   <= data_out_d;
            dram_en_rd <= rd_d;
            dram_en_wr <= wr_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_pool_layer.sv
// Bench for pool_layer: a 2x2x1 instance for window-level vectors and
// control corner cases, and a default 24x24x6 instance for full images.
// Both share one DRAM model; only one is ever enabled at a time.
module tb_pool_layer;

    localparam int AW = 18;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srstn;
    logic          sel;          // 0: small instance, 1: full instance
    logic          en_s, en_f;
    logic          stray;
    logic          resp_valid;
    logic [DW-1:0] dram_data;
    logic          valid_s, valid_f;

    logic [AW-1:0] s_addr_in, s_addr_out, f_addr_in, f_addr_out;
    logic [DW-1:0] s_data_out, f_data_out;
    logic          s_rd, s_wr, s_busy, s_done;
    logic          f_rd, f_wr, f_busy, f_done;

    logic [AW-1:0] m_addr_in, m_addr_out;
    logic [DW-1:0] m_data_out;
    logic          m_rd, m_wr, m_busy, m_done;

    assign valid_s = ~sel & (resp_valid | stray);
    assign valid_f =  sel & (resp_valid | stray);

    always_comb begin
        m_addr_in  = sel ? f_addr_in  : s_addr_in;
        m_addr_out = sel ? f_addr_out : s_addr_out;
        m_data_out = sel ? f_data_out : s_data_out;
        m_rd       = sel ? f_rd       : s_rd;
        m_wr       = sel ? f_wr       : s_wr;
        m_busy     = sel ? f_busy     : s_busy;
        m_done     = sel ? f_done     : s_done;
    end

    pool_layer #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .IN_W (2), .IN_H (2), .CH (1),
        .SRC_BASE (0), .DST_BASE (4096)
    ) u_small (
        .clk (clk), .srstn (srstn), .enable (en_s), .data_in (dram_data), .valid (valid_s),
        .addr_in (s_addr_in), .dram_en_rd (s_rd), .addr_out (s_addr_out),
        .data_out (s_data_out), .dram_en_wr (s_wr), .busy (s_busy), .done (s_done)
    );

    pool_layer #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .IN_W (24), .IN_H (24), .CH (6),
        .SRC_BASE (0), .DST_BASE (4096)
    ) u_full (
        .clk (clk), .srstn (srstn), .enable (en_f), .data_in (dram_data), .valid (valid_f),
        .addr_in (f_addr_in), .dram_en_rd (f_rd), .addr_out (f_addr_out),
        .data_out (f_data_out), .dram_en_wr (f_wr), .busy (f_busy), .done (f_done)
    );

    // ---------------- DRAM model and bookkeeping ----------------
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] wr_img [int];
    wr_t           exp_q [$];
    logic [AW-1:0] rd_log [$];

    int  errors = 0, checks = 0;
    int  wr_cnt = 0, done_cnt = 0, busy_cycles = 0, valid_cnt = 0;
    bit  lat_rand = 1'b0;
    int  lat_fixed = 1;
    bit  pend = 1'b0;
    int  cnt = 0;
    logic [AW-1:0] pend_addr = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Read responder with per-request latency, write sink and cycle counters
    always @(negedge clk) begin
        if (!srstn) begin
            pend       = 1'b0;
            resp_valid = 1'b0;
        end else begin
            resp_valid = 1'b0;
            dram_data  = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    resp_valid = 1'b1;
                    dram_data  = mem[pend_addr];
                    pend       = 1'b0;
                    valid_cnt++;
                end
            end
            if (m_rd) begin
                chk("one_outstanding", 32'(pend), 32'd0);
                rd_log.push_back(m_addr_in);
                pend      = 1'b1;
                pend_addr = m_addr_in;
                cnt       = lat_rand ? int'($urandom_range(1, 5)) : lat_fixed;
            end
            if (m_rd || m_wr) chk("rd_wr_overlap", 32'(m_rd & m_wr), 32'd0);
            if (m_wr) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wr_extra_addr", 32'(m_addr_out), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(m_addr_out), 32'(e.a));
                    chk("wr_data", m_data_out, e.d);
                end
                wr_img[int'(m_addr_out)] = m_data_out;
            end
            if (m_done) done_cnt++;
            if (m_busy) busy_cycles++;
        end
    end

    // ---------------- reference model ----------------
    // Pooled maps in write order: max over each 2x2 window of signed values
    task automatic build_expected(input int nch, input int iw, input int ih,
                                  input int src, input int dst);
        for (int ch = 0; ch < nch; ch++)
            for (int r = 0; r < ih / 2; r++)
                for (int c = 0; c < iw / 2; c++) begin
                    logic signed [DW-1:0] best, v;
                    int base;
                    wr_t e;
                    base = src + ch * iw * ih;
                    best = mem[base + 2 * r * iw + 2 * c];
                    for (int t = 1; t < 4; t++) begin
                        v = mem[base + (2 * r + t / 2) * iw + 2 * c + t % 2];
                        if (v > best) best = v;
                    end
                    e.a = AW'(dst + ch * (iw / 2) * (ih / 2) + r * (iw / 2) + c);
                    e.d = best;
                    exp_q.push_back(e);
                end
    endtask

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic [DW-1:0] w0, w1, w2, w3;
        logic [DW-1:0] exp;
        int            lat;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c,
                                logic [DW-1:0] d, logic [DW-1:0] x, int lat);
        vec_t v;
        v.w0 = a; v.w1 = b; v.w2 = c; v.w3 = d; v.exp = x; v.lat = lat;
        return v;
    endfunction

    task automatic pulse_en(input bit which);
        @(negedge clk);
        if (which) en_f = 1'b1; else en_s = 1'b1;
        @(negedge clk);
        en_s = 1'b0;
        en_f = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual=no done after %0d cycles required=done", tag, n);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_addr_in"},  32'(m_addr_in),  32'd0);
        chk({tag, "_addr_out"}, 32'(m_addr_out), 32'd0);
        chk({tag, "_data_out"}, m_data_out,      32'd0);
        chk({tag, "_rd"},       32'(m_rd),       32'd0);
        chk({tag, "_wr"},       32'(m_wr),       32'd0);
        chk({tag, "_busy"},     32'(m_busy),     32'd0);
        chk({tag, "_done"},     32'(m_done),     32'd0);
    endtask

    task automatic load_small(input int i);
        mem[0] = vecs[i].w0;
        mem[1] = vecs[i].w1;
        mem[2] = vecs[i].w2;
        mem[3] = vecs[i].w3;
    endtask

    task automatic check_small_run(input string tag, input logic [DW-1:0] exp,
                                   input int lat, input int d0, input int b0, input int w0);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_wr_cnt"},   32'(wr_cnt - w0),   32'd1);
        chk({tag, "_busy_cyc"}, 32'(busy_cycles - b0), 32'(4 * (1 + lat) + 1));
        chk({tag, "_exp_left"}, 32'(exp_q.size()),  32'd0);
        chk({tag, "_img"},      wr_img.exists(4096) ? wr_img[4096] : 32'hDEAD_0000, exp);
        chk({tag, "_rd_cnt"},   32'(rd_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < rd_log.size(); k++)
            chk({tag, "_rd_addr"}, 32'(rd_log[k]), 32'(k));
        exp_q.delete();
    endtask

    task automatic check_image(input string tag);
        for (int ch = 0; ch < 6; ch++)
            for (int r = 0; r < 12; r++)
                for (int c = 0; c < 12; c++) begin
                    int a;
                    a = 4096 + ch * 144 + r * 12 + c;
                    chk(tag, wr_img.exists(a) ? wr_img[a] : 32'hDEAD_0000,
                        32'(ch * 576 + (2 * r + 1) * 24 + 2 * c + 1));
                end
    endtask

    task automatic run_full(input string tag, input int lat_max);
        int d0, b0, w0;
        d0 = done_cnt; b0 = busy_cycles; w0 = wr_cnt;
        wr_img.delete();
        pulse_en(1'b1);
        wait_done(tag, 864 * (4 * (1 + lat_max) + 1) + 200);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_wr_cnt"},   32'(wr_cnt - w0),   32'd864);
        chk({tag, "_exp_left"}, 32'(exp_q.size()),  32'd0);
        if (!lat_rand) chk({tag, "_busy_cyc"}, 32'(busy_cycles - b0), 32'(864 * (4 * (1 + lat_max) + 1)));
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0, b0, w0, v0, n;
        srstn = 1'b0; sel = 1'b0; en_s = 1'b0; en_f = 1'b0; stray = 1'b0;
        resp_valid = 1'b0; dram_data = '0;

        vecs[0] = mk(32'd3,          32'(-7),        32'd9,          32'd1,          32'd9,          1);
        vecs[1] = mk(32'(-5),        32'(-2),        32'(-8),        32'(-2),        32'(-2),        2);
        vecs[2] = mk(32'd5,          32'd5,          32'd5,          32'd5,          32'd5,          3);
        vecs[3] = mk(32'h8000_0000,  32'h8000_0001,  32'h8000_0000,  32'h7FFF_FFFF,  32'h7FFF_FFFF,  1);
        vecs[4] = mk(32'h7FFF_FFFF,  32'(-1),        32'd0,          32'h8000_0000,  32'h7FFF_FFFF,  5);
        vecs[5] = mk(32'(-1),        32'(-1),        32'(-1),        32'(-1),        32'hFFFF_FFFF,  1);
        vecs[6] = mk(32'(-3),        32'(-4),        32'(-1),        32'(-9),        32'(-1),        4);
        vecs[7] = mk(32'd0,          32'd1,          32'h8000_0000,  32'd2,          32'd2,          2);

        // Reset state of both instances
        repeat (3) @(negedge clk);
        sel = 1'b0; #1; check_outputs_zero("rst_small");
        sel = 1'b1; #1; check_outputs_zero("rst_full");
        sel = 1'b0;
        @(negedge clk);
        srstn = 1'b1;
        repeat (2) @(negedge clk);

        // Window vectors on the 2x2 instance
        for (int i = 0; i < 8; i++) begin
            wr_t e;
            load_small(i);
            e.a = AW'(4096); e.d = vecs[i].exp;
            exp_q.push_back(e);
            rd_log.delete(); wr_img.delete();
            lat_rand = 1'b0; lat_fixed = vecs[i].lat;
            d0 = done_cnt; b0 = busy_cycles; w0 = wr_cnt;
            pulse_en(1'b0);
            wait_done("vec", 200);
            repeat (2) @(negedge clk);
            check_small_run($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat, d0, b0, w0);
        end

        // Asynchronous reset after two of four reads have returned, then a clean restart
        begin
            wr_t e;
            load_small(0);
            lat_fixed = 2;
            rd_log.delete(); wr_img.delete();
            v0 = valid_cnt; w0 = wr_cnt;
            pulse_en(1'b0);
            n = 0;
            while ((valid_cnt - v0) < 2 && n < 100) begin @(posedge clk); n++; end
            chk("mid_rst_valids", 32'(valid_cnt - v0), 32'd2);
            chk("mid_rst_busy_before", 32'(m_busy), 32'd1);
            @(negedge clk); #2;
            srstn = 1'b0;
            #1;
            check_outputs_zero("mid_rst");
            chk("mid_rst_no_write", 32'(wr_cnt - w0), 32'd0);
            repeat (3) @(negedge clk);
            srstn = 1'b1;
            e.a = AW'(4096); e.d = 32'd9;
            exp_q.push_back(e);
            rd_log.delete(); wr_img.delete();
            d0 = done_cnt; b0 = busy_cycles; w0 = wr_cnt;
            pulse_en(1'b0);
            wait_done("restart", 200);
            repeat (2) @(negedge clk);
            check_small_run("restart", 32'd9, 2, d0, b0, w0);
        end

        // Stray valid in IDLE, valid+enable together, enable re-pulsed while busy and in DONE
        begin
            wr_t e;
            load_small(1);
            lat_fixed = 1;
            rd_log.delete(); wr_img.delete();
            d0 = done_cnt; b0 = busy_cycles; w0 = wr_cnt;
            @(negedge clk); stray = 1'b1;
            @(negedge clk); stray = 1'b0;
            repeat (4) @(negedge clk);
            chk("stray_busy",  32'(m_busy), 32'd0);
            chk("stray_reads", 32'(rd_log.size()), 32'd0);
            chk("stray_wr",    32'(wr_cnt - w0), 32'd0);
            e.a = AW'(4096); e.d = 32'(-2);
            exp_q.push_back(e);
            stray = 1'b1; en_s = 1'b1;
            @(negedge clk); stray = 1'b0; en_s = 1'b0;
            repeat (3) @(negedge clk);
            en_s = 1'b1;
            @(negedge clk); en_s = 1'b0;
            repeat (2) @(negedge clk);
            en_s = 1'b1;
            @(negedge clk); en_s = 1'b0;
            n = 0;
            while (!m_done && n < 200) begin @(negedge clk); n++; end
            chk("redo_done_seen", 32'(m_done), 32'd1);
            en_s = 1'b1;
            @(negedge clk); en_s = 1'b0;
            repeat (20) @(negedge clk);
            check_small_run("redo", 32'(-2), 1, d0, b0, w0);
            chk("redo_idle_busy", 32'(m_busy), 32'd0);
        end

        // Full 24x24x6 ramp image, unit latency
        sel = 1'b1;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 3456; a++) mem[a] = 32'(a);
        lat_rand = 1'b0; lat_fixed = 1;
        build_expected(6, 24, 24, 0, 4096);
        run_full("ramp_l1", 1);
        check_image("ramp_l1_img");

        // Same image with per-read latency 1..5
        build_expected(6, 24, 24, 0, 4096);
        lat_rand = 1'b1;
        run_full("ramp_lrand", 5);
        check_image("ramp_lrand_img");

        // Random signed data with random latency
        for (int a = 0; a < 3456; a++) mem[a] = $urandom;
        build_expected(6, 24, 24, 0, 4096);
        run_full("rand_data", 5);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=time limit reached required=finished");
        $fatal(1);
    end

endmodule
